// File: rtl/vx_dcr_write_master_if.sv
// Host request port, DCR write strobe and status signals of the DCR write master.
interface vx_dcr_write_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  gpu_busy;
    logic                  dcr_write_valid;
    logic [ADDR_WIDTH-1:0] dcr_write_addr;
    logic [DATA_WIDTH-1:0] dcr_write_data;
    logic [CNT_WIDTH-1:0]  drop_count;
    logic [ADDR_WIDTH-1:0] last_drop_addr;
    logic                  idle;

    modport master (
        input  req_valid, req_addr, req_data, gpu_busy,
        output req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data,
        output drop_count, last_drop_addr, idle
    );

    modport slave (
        output req_valid, req_addr, req_data, gpu_busy,
        input  req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data,
        input  drop_count, last_drop_addr, idle
    );
endinterface

// File: rtl/vx_dcr_write_master.sv
// Buffers host config writes and replays them as single-cycle DCR pulses, 2 cycles after accept.
// req_ready falls only when the FIFO is full; the DCR side has no backpressure, so each write goes out once.
module vx_dcr_write_master #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    GAP_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BEGIN = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0] ADDR_END   = ADDR_WIDTH'(256),
    parameter int                    CNT_WIDTH  = 8
) (
    input logic                   clk,
    input logic                   reset,
    vx_dcr_write_master_if.master bus
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = PW + 1;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [GW-1:0]         gap_cnt;
    logic [ADDR_WIDTH-1:0] out_addr, drop_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  drop_cnt;
    logic fifo_full, fifo_empty, in_range, accept, push, drop, pop_slot, pop;
    logic write_valid, idle_flag;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign in_range   = (bus.req_addr >= ADDR_BEGIN) && (bus.req_addr < ADDR_END);
    assign accept     = bus.req_valid && !fifo_full;
    assign push       = accept && in_range;
    assign drop       = accept && !in_range;

    // The issuer can pop in IDLE and also in the final cycle of ISSUE/GAP, so
    // the programmed gap is exactly GAP_CYCLES dead cycles between pulses.
    always_comb begin
        pop_slot = 1'b0;
        case (state)
            S_IDLE:  pop_slot = 1'b1;
            S_ISSUE: pop_slot = (GAP_CYCLES == 0);
            S_GAP:   pop_slot = (gap_cnt == GAP_LAST);
            default: pop_slot = 1'b0;
        endcase
    end

    assign pop = pop_slot && !fifo_empty && !bus.gpu_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = pop ? S_ISSUE : ((GAP_CYCLES > 0) ? S_GAP : S_IDLE);
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = pop ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        write_valid = (state == S_ISSUE);
        idle_flag   = fifo_empty && (state == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt + GW'(1);
        end else begin
            gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {bus.req_addr, bus.req_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            drop_cnt  <= '0;
            drop_addr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr               <= rd_ptr + PTR_W'(1);
                {out_addr, out_data} <= mem[rd_ptr[PW-1:0]];
            end
            if (drop) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                drop_addr <= bus.req_addr;
            end
        end
    end

    assign bus.req_ready       = !fifo_full;
    assign bus.dcr_write_valid = write_valid;
    assign bus.dcr_write_addr  = out_addr;
    assign bus.dcr_write_data  = out_data;
    assign bus.drop_count      = drop_cnt;
    assign bus.last_drop_addr  = drop_addr;
    assign bus.idle            = idle_flag;
endmodule
